// File: rtl/pwr_cntr_ctrl.sv
// Counter-memory controller: clears, dumps and saturating-increments 32-bit
// counters held in an external single-port memory, with four round-robin requesters.
module pwr_cntr_ctrl #(
    parameter int NDIR = 4,
    parameter int NCNT = 15
) (
    input  logic                  CLK,
    input  logic                  CLR,
    input  logic                  start_clr,
    input  logic                  start_dump,
    input  logic [3:0]            req,
    input  logic [4*(NDIR+1)-1:0] reqdir,
    output logic [3:0]            ack,
    output logic                  err,
    output logic                  busy,
    output logic [NDIR:0]         dir,
    output logic                  LE,
    inout  wire  [31:0]           dato,
    output logic                  dump_valid,
    output logic [NDIR:0]         dump_dir,
    output logic [31:0]           dump_data
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_RD    = 3'd2;
    localparam logic [2:0] S_WR    = 3'd3;
    localparam logic [2:0] S_DUMP  = 3'd4;

    localparam logic [NDIR:0] LAST = (NDIR+1)'(NCNT);
    localparam logic [NDIR:0] ONE  = (NDIR+1)'(1);

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [2:0]    state_q, state_d;
    logic [NDIR:0] dir_q, dir_d;
    logic [1:0]    rr_ptr_q, rr_ptr_d;
    logic [1:0]    win_q, win_d;
    logic [31:0]   hold_q, hold_d;
    logic          dump_valid_q, dump_valid_d;
    logic [NDIR:0] dump_dir_q, dump_dir_d;
    logic [31:0]   dump_data_q, dump_data_d;

    logic [1:0]    arb_win;
    logic [1:0]    arb_idx;
    logic          oob;
    logic [31:0]   dato_drv;

    // Scan downwards so the channel closest to rr_ptr is the last one to claim the grant.
    always_comb begin
        arb_win = rr_ptr_q;
        arb_idx = rr_ptr_q;
        for (int k = 3; k >= 0; k--) begin
            arb_idx = rr_ptr_q + 2'(k);
            if (req[arb_idx]) begin
                arb_win = arb_idx;
            end
        end
    end

    assign oob = (dir_q > LAST);

    always_comb begin
        state_d      = state_q;
        dir_d        = dir_q;
        rr_ptr_d     = rr_ptr_q;
        win_d        = win_q;
        hold_d       = hold_q;
        dump_valid_d = 1'b0;
        dump_dir_d   = dump_dir_q;
        dump_data_d  = dump_data_q;
        case (state_q)
            S_IDLE: begin
                if (start_clr) begin
                    state_d = S_CLEAR;
                    dir_d   = '0;
                end else if (start_dump) begin
                    state_d = S_DUMP;
                    dir_d   = '0;
                end else if (|req) begin
                    state_d = S_RD;
                    win_d   = arb_win;
                    dir_d   = reqdir[int'(arb_win)*(NDIR+1) +: (NDIR+1)];
                end
            end
            S_CLEAR: begin
                if (dir_q == LAST) state_d = S_IDLE;
                else               dir_d   = dir_q + ONE;
            end
            S_RD: begin
                hold_d  = dato;
                state_d = S_WR;
            end
            S_WR: begin
                rr_ptr_d = win_q + 2'd1;
                state_d  = S_IDLE;
            end
            S_DUMP: begin
                dump_valid_d = 1'b1;
                dump_dir_d   = dir_q;
                dump_data_d  = dato;
                if (dir_q == LAST) state_d = S_IDLE;
                else               dir_d   = dir_q + ONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q      <= S_IDLE;
            dir_q        <= '0;
            rr_ptr_q     <= '0;
            win_q        <= '0;
            hold_q       <= '0;
            dump_valid_q <= 1'b0;
            dump_dir_q   <= '0;
            dump_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            rr_ptr_q     <= rr_ptr_d;
            win_q        <= win_d;
            hold_q       <= hold_d;
            dump_valid_q <= dump_valid_d;
            dump_dir_q   <= dump_dir_d;
            dump_data_q  <= dump_data_d;
        end
    end

    // Out-of-range winners still run RD/WR but keep the bus in read mode so nothing is written.
    assign LE       = !((state_q == S_CLEAR) || ((state_q == S_WR) && !oob));
    assign dato_drv = (state_q == S_CLEAR) ? 32'h0 : sat_inc(hold_q);
    assign dato     = LE ? 32'bz : dato_drv;

    assign busy       = (state_q != S_IDLE);
    assign dir        = dir_q;
    assign ack        = (state_q == S_WR) ? (4'b0001 << win_q) : 4'b0000;
    assign err        = (state_q == S_WR) && oob;
    assign dump_valid = dump_valid_q;
    assign dump_dir   = dump_dir_q;
    assign dump_data  = dump_data_q;

endmodule

// File: tb/tb_pwr_cntr_ctrl.sv
// Scoreboard bench for pwr_cntr_ctrl: a behavioural counter-array model predicts
// acks and dump contents; a negedge monitor retires predictions as outputs appear.
module tb_pwr_cntr_ctrl;

    localparam int NDIR  = 4;
    localparam int NCNT  = 15;
    localparam int AW    = NDIR + 1;
    localparam int DEPTH = 1 << AW;

    logic            CLK = 1'b0;
    logic            CLR = 1'b0;
    logic            start_clr = 1'b0;
    logic            start_dump = 1'b0;
    logic [3:0]      req = 4'b0;
    logic [4*AW-1:0] reqdir = '0;
    logic [3:0]      ack;
    logic            err;
    logic            busy;
    logic [AW-1:0]   dir;
    logic            LE;
    wire  [31:0]     dato;
    logic            dump_valid;
    logic [AW-1:0]   dump_dir;
    logic [31:0]     dump_data;

    logic [31:0]     mem [DEPTH];
    logic            pre_we = 1'b0;
    logic [AW-1:0]   pre_addr = '0;
    logic [31:0]     pre_data = '0;

    logic [31:0]     ref_mem [DEPTH];
    int              m_ptr = 0;
    int              cyc = 0;
    int              n_total = 0;
    int              n_pass = 0;

    typedef struct {
        bit          kd;
        int          ch;
        bit          er;
        int          ad;
        logic [31:0] dt;
    } exp_t;
    exp_t exp_q[$];

    pwr_cntr_ctrl #(.NDIR(NDIR), .NCNT(NCNT)) dut (
        .CLK(CLK), .CLR(CLR), .start_clr(start_clr), .start_dump(start_dump),
        .req(req), .reqdir(reqdir), .ack(ack), .err(err), .busy(busy),
        .dir(dir), .LE(LE), .dato(dato), .dump_valid(dump_valid),
        .dump_dir(dump_dir), .dump_data(dump_data)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // External counter memory: combinational read, write on the clock edge.
    assign dato = LE ? mem[dir] : 32'bz;
    always @(posedge CLK) begin
        if (!LE) mem[dir] <= dato;
        else if (pre_we) mem[pre_addr] <= pre_data;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_total++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (CLR) begin
            if (ack != 4'b0 || err) begin
                if (exp_q.size() == 0) check("ack_unexpected", {ack, err}, 5'b0);
                else begin
                    e = exp_q.pop_front();
                    check("ack_kind", e.kd, 1'b0);
                    check("ack_ch", ack, 4'b1 << e.ch);
                    check("ack_err", err, e.er);
                end
            end
            if (dump_valid) begin
                if (exp_q.size() == 0) check("dump_unexpected", dump_valid, 1'b0);
                else begin
                    e = exp_q.pop_front();
                    check("dump_kind", e.kd, 1'b1);
                    check("dump_dir", dump_dir, e.ad);
                    check("dump_data", dump_data, e.dt);
                end
            end
        end
    end

    task automatic preload(input int a, input logic [31:0] v);
        @(negedge CLK);
        pre_we = 1'b1; pre_addr = AW'(a); pre_data = v;
        @(negedge CLK);
        pre_we = 1'b0;
        ref_mem[a] = v;
    endtask

    task automatic check_mem();
        @(negedge CLK);
        for (int a = 0; a < DEPTH; a++) check($sformatf("mem[%0d]", a), mem[a], ref_mem[a]);
    endtask

    task automatic do_clear();
        @(negedge CLK);
        start_clr = 1'b1;
        @(negedge CLK);
        start_clr = 1'b0;
        for (int k = 0; k <= NCNT; k++) begin
            check("clr_bus", {busy, LE, dir, dato}, {1'b1, 1'b0, AW'(k), 32'h0});
            @(negedge CLK);
        end
        check("clr_done_busy", busy, 1'b0);
        for (int a = 0; a <= NCNT; a++) ref_mem[a] = 32'h0;
    endtask

    task automatic do_dump();
        int w;
        for (int a = 0; a <= NCNT; a++) exp_q.push_back('{kd: 1'b1, ch: 0, er: 1'b0, ad: a, dt: ref_mem[a]});
        @(negedge CLK);
        start_dump = 1'b1;
        @(negedge CLK);
        start_dump = 1'b0;
        w = 0;
        while (busy && w < 100) begin
            @(negedge CLK);
            w++;
        end
        check("dump_end", busy, 1'b0);
        @(negedge CLK);
        check("dump_drained", exp_q.size(), 0);
    endtask

    // Predict service order from the round-robin rule, update the counter model, then drive.
    task automatic do_incr(input logic [3:0] mask, input logic [4*AW-1:0] dirs,
                           input bit chk_lat, input bit with_starts);
        logic [3:0] pend;
        int ptr, i, a, n, got, t0, last;
        bit first;
        if (with_starts) for (int k = 0; k <= NCNT; k++) ref_mem[k] = 32'h0;
        pend = mask;
        ptr  = m_ptr;
        while (pend != 4'b0) begin
            i = -1;
            for (int k = 0; k < 4 && i < 0; k++) if (pend[(ptr + k) % 4]) i = (ptr + k) % 4;
            a = int'(dirs[i*AW +: AW]);
            exp_q.push_back('{kd: 1'b0, ch: i, er: (a > NCNT), ad: a, dt: 32'h0});
            if (a <= NCNT && ref_mem[a] != 32'hFFFF_FFFF) ref_mem[a] = ref_mem[a] + 32'd1;
            pend[i] = 1'b0;
            ptr = (i + 1) % 4;
        end
        m_ptr = ptr;
        @(negedge CLK);
        reqdir = dirs;
        req    = mask;
        if (with_starts) begin
            start_clr  = 1'b1;
            start_dump = 1'b1;
        end
        n = $countones(mask);
        got = 0; t0 = cyc; last = cyc; first = 1'b1;
        while (got < n && cyc - t0 < 80) begin
            @(negedge CLK);
            if (first) begin
                start_clr  = 1'b0;
                start_dump = 1'b0;
                first = 1'b0;
            end
            if (ack != 4'b0) begin
                if (chk_lat) check("ack_latency", cyc - last, (got == 0) ? 2 : 3);
                last = cyc;
                req = req & ~ack;
                got++;
            end
        end
        check("ack_count", got, n);
        req = 4'b0;
        @(negedge CLK);
    endtask

    initial begin
        logic [3:0]      mask;
        logic [4*AW-1:0] d;
        int              w;

        repeat (2) @(negedge CLK);
        check("rst_outputs", {busy, LE, dir, ack, err, dump_valid, dump_dir, dump_data},
              {1'b0, 1'b1, AW'(0), 4'b0, 1'b0, 1'b0, AW'(0), 32'h0});
        CLR = 1'b1;
        for (int a = 0; a < DEPTH; a++) preload(a, $urandom());

        do_clear();
        check_mem();
        do_dump();

        // Four channels on one counter from rr_ptr=0, then a single increment of 7.
        do_incr(4'b1111, {AW'(5), AW'(5), AW'(5), AW'(5)}, 1'b1, 1'b0);
        check("mem5_four", mem[5], 32'd4);
        preload(3, 32'd7);
        do_incr(4'b0001, {AW'(0), AW'(0), AW'(0), AW'(3)}, 1'b1, 1'b0);
        check("mem3_eight", mem[3], 32'd8);

        preload(2, 32'hFFFF_FFFF);
        do_incr(4'b0010, {AW'(0), AW'(0), AW'(2), AW'(0)}, 1'b1, 1'b0);
        do_incr(4'b0100, {AW'(0), AW'(20), AW'(0), AW'(0)}, 1'b1, 1'b0);
        check_mem();

        // Both start requests plus a pending increment: clear wins, dump is dropped.
        do_incr(4'b0100, {AW'(0), AW'(4), AW'(0), AW'(0)}, 1'b0, 1'b1);
        check("mem4_after_clr", mem[4], 32'd1);
        do_dump();

        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 3) == 0) preload($urandom_range(0, NCNT), 32'hFFFF_FFFF - $urandom_range(0, 2));
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < 4; i++)
                d[i*AW +: AW] = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(NCNT + 1, DEPTH - 1))
                                                           : AW'($urandom_range(0, 5));
            do_incr(mask, d, 1'b1, 1'b0);
            if (it % 6 == 5) begin
                check_mem();
                do_dump();
            end
        end

        // Abort a clear part way through and confirm the tail of the array is untouched.
        for (int a = 0; a <= NCNT; a++) preload(a, 32'h100 + a);
        @(negedge CLK);
        start_clr = 1'b1;
        @(negedge CLK);
        start_clr = 1'b0;
        w = 0;
        while (dir != AW'(6) && w < 50) begin
            @(negedge CLK);
            w++;
        end
        check("clr_reach6", dir, 6);
        CLR = 1'b0;
        #1;
        check("abort_outputs", {busy, LE, dir, ack, err, dump_valid, dump_dir, dump_data},
              {1'b0, 1'b1, AW'(0), 4'b0, 1'b0, 1'b0, AW'(0), 32'h0});
        for (int a = 0; a < 6; a++) ref_mem[a] = 32'h0;
        m_ptr = 0;
        repeat (2) @(negedge CLK);
        check("abort_idle", busy, 1'b0);
        CLR = 1'b1;
        check_mem();
        do_dump();
        do_incr(4'b1010, {AW'(9), AW'(0), AW'(9), AW'(0)}, 1'b1, 1'b0);
        check_mem();

        check("final_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end

endmodule
